// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with bounded req/ack waits and a sticky TRAP.
// Optional build macro MCU_PERF_COUNTERS_EN adds cycle_cnt/instret_cnt outputs.
module multicycle_control_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        im_ack,
    input  logic        dm_ack,
    input  logic        branch_taken,
    output logic        im_req,
    output logic        dm_req,
    output logic        DM_wen,
    output logic        IR_wen,
    output logic        PC_wen,
    output logic        PC_sel,
    output logic [4:0]  RF_rsel1,
    output logic [4:0]  RF_rsel2,
    output logic [4:0]  RF_wsel,
    output logic        RF_wen,
    output logic [1:0]  RF_wdata_sel,
    output logic        ALU_OP1_SEL,
    output logic        ALU_OP2_SEL,
    output logic [3:0]  ALU_Operation,
    output logic [2:0]  branch_condition,
    output logic        halt,
    output logic [1:0]  fault
`ifdef MCU_PERF_COUNTERS_EN
    ,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // ALU opcodes are {fn7[5], fn3}; ADD is the all-zero code used for address/target math.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_DM   = 2'd1;
    localparam logic [1:0] WD_PC4  = 2'd2;
    localparam logic [1:0] F_NONE  = 2'b00;
    localparam logic [1:0] F_ILL   = 2'b01;
    localparam logic [1:0] F_IMTO  = 2'b10;
    localparam logic [1:0] F_DMTO  = 2'b11;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       fault_q, fault_next;
    logic             timed_out;

    logic [6:0] opc;
    logic [2:0] fn3;
    logic [6:0] fn7;
    logic       is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_fence;
    logic       known, legal_op, legal_opi, illegal;
    logic       use_rs1, use_rs2, wr_rd, active;
    logic [3:0] alu_op;
    logic       op1_sel, op2_sel;
    logic [1:0] wdata_sel;

    assign opc = instruction[6:0];
    assign fn3 = instruction[14:12];
    assign fn7 = instruction[31:25];

    assign is_lui   = (opc == OPC_LUI);
    assign is_auipc = (opc == OPC_AUIPC);
    assign is_jal   = (opc == OPC_JAL);
    assign is_jalr  = (opc == OPC_JALR);
    assign is_br    = (opc == OPC_BRANCH);
    assign is_ld    = (opc == OPC_LOAD);
    assign is_st    = (opc == OPC_STORE);
    assign is_opi   = (opc == OPC_OPIMM);
    assign is_op    = (opc == OPC_OP);
    assign is_fence = (opc == OPC_FENCE);

    // SYSTEM (ECALL/EBREAK) is deliberately absent from the known list so it traps.
    assign known     = is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st
                     | is_opi | is_op | is_fence;
    assign legal_op  = (fn7 == 7'h00) || ((fn7 == 7'h20) && ((fn3 == 3'b000) || (fn3 == 3'b101)));
    assign legal_opi = !((fn3 == 3'b001) && (fn7 != 7'h00))
                    && !((fn3 == 3'b101) && (fn7 != 7'h00) && (fn7 != 7'h20));
    assign illegal   = !known || (is_op && !legal_op) || (is_opi && !legal_opi);

    assign use_rs1 = is_op | is_opi | is_jalr | is_br | is_ld | is_st;
    assign use_rs2 = is_op | is_br | is_st;
    assign wr_rd   = is_op | is_opi | is_lui | is_auipc | is_jal | is_jalr | is_ld;
    assign active  = (state == DECODE) || (state == EXEC) || (state == MEM) || (state == WB);

    assign timed_out = (cnt == CNT_W'(TIMEOUT));

    always_comb begin
        alu_op    = ALU_ADD;
        op1_sel   = 1'b0;
        op2_sel   = 1'b1;
        wdata_sel = WD_ALU;
        if (is_op) begin
            alu_op  = {fn7[5], fn3};
            op2_sel = 1'b0;
        end else if (is_opi) begin
            alu_op = (fn3 == 3'b101) ? {fn7[5], fn3} : {1'b0, fn3};
        end
        // LUI keeps op1 on the register port with rs1 forced to x0, so x0 + imm.
        if (is_auipc || is_jal || is_br) op1_sel = 1'b1;
        if (is_ld) wdata_sel = WD_DM;
        else if (is_jal || is_jalr) wdata_sel = WD_PC4;
    end

    always_comb begin
        state_next       = state;
        fault_next       = fault_q;
        im_req           = 1'b0;
        dm_req           = 1'b0;
        DM_wen           = 1'b0;
        IR_wen           = 1'b0;
        PC_wen           = 1'b0;
        PC_sel           = 1'b0;
        RF_wen           = 1'b0;
        RF_rsel1         = '0;
        RF_rsel2         = '0;
        RF_wsel          = '0;
        RF_wdata_sel     = WD_ALU;
        ALU_OP1_SEL      = 1'b0;
        ALU_OP2_SEL      = 1'b0;
        ALU_Operation    = '0;
        branch_condition = '0;
        halt             = 1'b0;
        fault            = F_NONE;
        if (rst_n) begin
            halt  = (state == TRAP);
            fault = fault_q;
            if (active && !illegal) begin
                RF_rsel1         = use_rs1 ? instruction[19:15] : 5'd0;
                RF_rsel2         = use_rs2 ? instruction[24:20] : 5'd0;
                RF_wsel          = wr_rd ? instruction[11:7] : 5'd0;
                RF_wdata_sel     = wdata_sel;
                ALU_OP1_SEL      = op1_sel;
                ALU_OP2_SEL      = op2_sel;
                ALU_Operation    = alu_op;
                branch_condition = is_br ? fn3 : 3'd0;
            end
            case (state)
                FETCH: begin
                    im_req = 1'b1;
                    if (im_ack) begin
                        IR_wen     = 1'b1;
                        state_next = DECODE;
                    end else if (timed_out) begin
                        state_next = TRAP;
                        fault_next = F_IMTO;
                    end
                end
                DECODE: begin
                    if (illegal) begin
                        state_next = TRAP;
                        fault_next = F_ILL;
                    end else if (is_fence) begin
                        PC_wen     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = EXEC;
                    end
                end
                EXEC: begin
                    if (is_br) begin
                        PC_wen     = 1'b1;
                        PC_sel     = branch_taken;
                        state_next = FETCH;
                    end else if (is_ld || is_st) begin
                        state_next = MEM;
                    end else begin
                        state_next = WB;
                    end
                end
                MEM: begin
                    dm_req = 1'b1;
                    DM_wen = is_st;
                    if (dm_ack) begin
                        if (is_st) begin
                            PC_wen     = 1'b1;
                            state_next = FETCH;
                        end else begin
                            state_next = WB;
                        end
                    end else if (timed_out) begin
                        state_next = TRAP;
                        fault_next = F_DMTO;
                    end
                end
                WB: begin
                    RF_wen     = 1'b1;
                    PC_wen     = 1'b1;
                    PC_sel     = is_jal | is_jalr;
                    state_next = FETCH;
                end
                default: state_next = TRAP;
            endcase
        end
    end

    // The wait counter restarts on any state change so each wait gets a full budget.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH;
            cnt     <= '0;
            fault_q <= F_NONE;
        end else begin
            state   <= state_next;
            fault_q <= fault_next;
            if (state_next != state) cnt <= '0;
            else if ((state == FETCH) || (state == MEM)) cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef MCU_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else if (state != TRAP) begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (active && (state_next == FETCH)) instret_cnt <= instret_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle strobe vectors plus field checks.
module tb_multicycle_control_unit;
    localparam int TO = 4;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_BADR  = 32'h202081B3;
    localparam logic [31:0] I_LW    = 32'h0080A283;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_BGE   = 32'h0020D463;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_FENCE = 32'h0000000F;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_BADOP = 32'h0000007F;

    // Strobe vector bits: {im_req, dm_req, DM_wen, IR_wen, PC_wen, PC_sel, RF_wen, halt}
    localparam logic [7:0] S_0    = 8'b0000_0000;
    localparam logic [7:0] S_F    = 8'b1001_0000;
    localparam logic [7:0] S_FW   = 8'b1000_0000;
    localparam logic [7:0] S_WB   = 8'b0000_1010;
    localparam logic [7:0] S_WBJ  = 8'b0000_1110;
    localparam logic [7:0] S_BT   = 8'b0000_1100;
    localparam logic [7:0] S_PC4  = 8'b0000_1000;
    localparam logic [7:0] S_MEM  = 8'b0100_0000;
    localparam logic [7:0] S_ST   = 8'b0110_1000;
    localparam logic [7:0] S_TRAP = 8'b0000_0001;

    logic        clk = 1'b0;
    logic        rst_n, im_ack, dm_ack, branch_taken;
    logic [31:0] instruction;
    logic        im_req, dm_req, DM_wen, IR_wen, PC_wen, PC_sel, RF_wen, ALU_OP1_SEL, ALU_OP2_SEL, halt;
    logic [4:0]  RF_rsel1, RF_rsel2, RF_wsel;
    logic [1:0]  RF_wdata_sel, fault;
    logic [3:0]  ALU_Operation;
    logic [2:0]  branch_condition;
    logic [7:0]  st;
`ifdef MCU_PERF_COUNTERS_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    int checks = 0;
    int errors = 0;

    multicycle_control_unit #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .im_ack(im_ack), .dm_ack(dm_ack),
        .branch_taken(branch_taken), .im_req(im_req), .dm_req(dm_req), .DM_wen(DM_wen),
        .IR_wen(IR_wen), .PC_wen(PC_wen), .PC_sel(PC_sel), .RF_rsel1(RF_rsel1),
        .RF_rsel2(RF_rsel2), .RF_wsel(RF_wsel), .RF_wen(RF_wen), .RF_wdata_sel(RF_wdata_sel),
        .ALU_OP1_SEL(ALU_OP1_SEL), .ALU_OP2_SEL(ALU_OP2_SEL), .ALU_Operation(ALU_Operation),
        .branch_condition(branch_condition), .halt(halt), .fault(fault)
`ifdef MCU_PERF_COUNTERS_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign st = {im_req, dm_req, DM_wen, IR_wen, PC_wen, PC_sel, RF_wen, halt};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [7:0] e);
        @(negedge clk);
        check(tag, {24'd0, st}, {24'd0, e});
    endtask

    task automatic fetch_dec(input string tag);
        cyc({tag, "_fetch"}, S_F);
        nxt();
        cyc({tag, "_dec"}, S_0);
        nxt();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc("reset_strobes", S_0);
        check("reset_fault", {30'd0, fault}, 32'd0);
        nxt();
        rst_n = 1'b1;
    endtask

    task automatic trap_check(input string tag, input logic [1:0] f);
        cyc({tag, "_trap"}, S_TRAP);
        check({tag, "_fault"}, {30'd0, fault}, {30'd0, f});
        nxt();
        nxt();
        cyc({tag, "_trap_sticky"}, S_TRAP);
        nxt();
    endtask

    initial begin
        rst_n = 1'b0; instruction = '0; im_ack = 1'b0; dm_ack = 1'b0; branch_taken = 1'b0;
        nxt();
        nxt();
        cyc("rst_strobes", S_0);
        check("rst_fault", {30'd0, fault}, 32'd0);
        check("rst_alu", {28'd0, ALU_Operation}, 32'd0);
        nxt();
        rst_n = 1'b1;

        // ADD with the ack arriving exactly when the count hits TIMEOUT
        instruction = I_ADD;
        for (int i = 0; i < TO; i++) begin
            cyc("add_fetch_wait", S_FW);
            nxt();
        end
        im_ack = 1'b1;
        cyc("add_fetch_tie", S_F);
        nxt();
        cyc("add_dec", S_0);
        check("add_rs1", {27'd0, RF_rsel1}, 32'd1);
        check("add_rs2", {27'd0, RF_rsel2}, 32'd2);
        nxt();
        cyc("add_exe", S_0);
        check("add_alu", {28'd0, ALU_Operation}, 32'd0);
        check("add_op1", {31'd0, ALU_OP1_SEL}, 32'd0);
        check("add_op2", {31'd0, ALU_OP2_SEL}, 32'd0);
        nxt();
        cyc("add_wb", S_WB);
        check("add_wsel", {27'd0, RF_wsel}, 32'd3);
        check("add_wdsel", {30'd0, RF_wdata_sel}, 32'd0);
        nxt();

        instruction = I_SUB;
        fetch_dec("sub");
        cyc("sub_exe", S_0);
        check("sub_alu", {28'd0, ALU_Operation}, 32'd8);
        nxt();
        cyc("sub_wb", S_WB);
        nxt();

        // LW: dm_ack withheld three cycles, so MEM lasts four
        instruction = I_LW;
        fetch_dec("lw");
        cyc("lw_exe", S_0);
        check("lw_rs1", {27'd0, RF_rsel1}, 32'd1);
        check("lw_rs2", {27'd0, RF_rsel2}, 32'd0);
        check("lw_op2", {31'd0, ALU_OP2_SEL}, 32'd1);
        nxt();
        for (int i = 0; i < 3; i++) begin
            cyc("lw_mem_wait", S_MEM);
            nxt();
        end
        dm_ack = 1'b1;
        cyc("lw_mem_ack", S_MEM);
        nxt();
        dm_ack = 1'b0;
        cyc("lw_wb", S_WB);
        check("lw_wdsel", {30'd0, RF_wdata_sel}, 32'd1);
        check("lw_wsel", {27'd0, RF_wsel}, 32'd5);
        nxt();

        instruction = I_SW;
        dm_ack = 1'b1;
        fetch_dec("sw");
        cyc("sw_exe", S_0);
        nxt();
        cyc("sw_mem", S_ST);
        check("sw_rs2", {27'd0, RF_rsel2}, 32'd2);
        nxt();
        dm_ack = 1'b0;

        instruction = I_BEQ;
        branch_taken = 1'b1;
        fetch_dec("beq_t");
        cyc("beq_t_exe", S_BT);
        check("beq_cond", {29'd0, branch_condition}, 32'd0);
        check("beq_op1", {31'd0, ALU_OP1_SEL}, 32'd1);
        check("beq_op2", {31'd0, ALU_OP2_SEL}, 32'd1);
        nxt();
        branch_taken = 1'b0;
        fetch_dec("beq_n");
        cyc("beq_n_exe", S_PC4);
        nxt();
        instruction = I_BGE;
        fetch_dec("bge");
        cyc("bge_exe", S_PC4);
        check("bge_cond", {29'd0, branch_condition}, 32'd5);
        nxt();

        instruction = I_JALR;
        fetch_dec("jalr");
        cyc("jalr_exe", S_0);
        check("jalr_alu", {28'd0, ALU_Operation}, 32'd0);
        check("jalr_op1", {31'd0, ALU_OP1_SEL}, 32'd0);
        check("jalr_rs1", {27'd0, RF_rsel1}, 32'd2);
        nxt();
        cyc("jalr_wb", S_WBJ);
        check("jalr_wdsel", {30'd0, RF_wdata_sel}, 32'd2);
        check("jalr_wsel", {27'd0, RF_wsel}, 32'd1);
        nxt();

        instruction = I_FENCE;
        cyc("fence_fetch", S_F);
        nxt();
        cyc("fence_dec", S_PC4);
        nxt();

        instruction = I_BADOP;
        fetch_dec("badop");
        trap_check("badop", 2'b01);
        do_reset();
        instruction = I_ECALL;
        fetch_dec("ecall");
        trap_check("ecall", 2'b01);
        do_reset();
        instruction = I_BADR;
        fetch_dec("badfn7");
        trap_check("badfn7", 2'b01);
        do_reset();

        // DM timeout: five MEM cycles (count 0..TIMEOUT) then TRAP
        instruction = I_LW;
        fetch_dec("dmto");
        cyc("dmto_exe", S_0);
        nxt();
        for (int i = 0; i <= TO; i++) begin
            cyc("dmto_mem", S_MEM);
            nxt();
        end
        trap_check("dmto", 2'b11);
        do_reset();

        // IM timeout, then ack arriving in TRAP must not revive it
        im_ack = 1'b0;
        for (int i = 0; i <= TO; i++) begin
            cyc("imto_fetch", S_FW);
            nxt();
        end
        im_ack = 1'b1;
        trap_check("imto", 2'b10);
        im_ack = 1'b0;
        do_reset();
        cyc("imto_after_reset", S_FW);
        check("imto_after_fault", {30'd0, fault}, 32'd0);
        nxt();

        // Reset while a load is waiting in MEM
        im_ack = 1'b1;
        fetch_dec("rstmem");
        cyc("rstmem_exe", S_0);
        nxt();
        cyc("rstmem_mem", S_MEM);
        nxt();
        rst_n = 1'b0;
        cyc("rstmem_in_reset", S_0);
        nxt();
        cyc("rstmem_after_edge", S_0);
        nxt();
        rst_n = 1'b1;
        cyc("rstmem_refetch", S_F);
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
FSM-based control unit for the next-generation multicycle RV32I core. It replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB sequence. Instruction and data memories use a req/ack handshake with a bounded wait. It drives the same datapath select encodings (ALU ops, RF write-data select, operand selects, branch condition) plus PC/IR write enables, and halts on illegal instructions or memory timeout.

Parameters:
TIMEOUT, 255, maximum cycles to wait for im_ack/dm_ack before faulting (1..65535)
CNT_W, 16, width of the internal wait counter; must hold TIMEOUT

Ports:
clk  in  1  core clock
rst_n  in  1  reset; one clock domain, synchronous, active-low
instruction  in  32  current IR contents (valid from DECODE onward)
im_ack  in  1  instruction memory data valid, same cycle as IR capture
dm_ack  in  1  data memory transfer complete
branch_taken  in  1  comparator result for current branch_condition
im_req  out  1  instruction fetch request
dm_req  out  1  data memory request
DM_wen  out  1  store qualifier, valid while dm_req=1
IR_wen  out  1  latch instruction into IR
PC_wen  out  1  update PC
PC_sel  out  1  0: PC+4, 1: ALU result
RF_rsel1  out  5  rs1 (0 when unused)
RF_rsel2  out  5  rs2 (0 when unused)
RF_wsel  out  5  rd
RF_wen  out  1  register file write strobe
RF_wdata_sel  out  2  ALU / DM / PC+4 select, existing encodings
ALU_OP1_SEL  out  1  existing encoding
ALU_OP2_SEL  out  1  existing encoding
ALU_Operation  out  4  existing ALU encodings
branch_condition  out  3  fn3 for B-type, else 0
halt  out  1  sticky; core stopped
fault  out  2  00 none, 01 illegal/ECALL/EBREAK, 10 IM timeout, 11 DM timeout

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Register updates occur only on the rising edge of clk.
- Reset: while rst_n=0, every output is 0 and the state loads FETCH, the counter loads 0, halt and fault load 0. Reset mid-transfer drops im_req/dm_req with no PC/RF/DM side effects.
- FETCH: im_req=1. On im_ack, IR_wen=1 and go to DECODE. Otherwise count; when the count reaches TIMEOUT, go to TRAP with fault=10.
- DECODE:
  - Illegal opcode, R-type with bad fn7, ECALL, or EBREAK: go to TRAP with fault=01.
  - FENCE: PC_wen=1, PC_sel=0, go to FETCH (NOP).
  - Otherwise go to EXEC. RF_rsel1/2 are driven from DECODE through WB.
- EXEC: ALU_Operation and operand selects follow RV32I. AUIPC, JAL, JALR and branches use PC/reg + imm on the ALU. JALR is decoded as I-type add.
  - Branch: PC_wen=1, PC_sel=branch_taken, then FETCH.
  - Load/store: go to MEM.
  - All other instructions: go to WB.
- MEM: dm_req=1 and DM_wen=(store); ALU outputs are held stable. On dm_ack, a store sets PC_wen=1, PC_sel=0 and goes to FETCH; a load goes to WB. Timeout goes to TRAP with fault=11.
- WB: RF_wen=1 for one cycle, plus PC_wen=1.
  - RF_wdata_sel: DM for loads, PC+4 for JAL/JALR, ALU otherwise.
  - PC_sel=1 for JAL/JALR (ALU target), 0 otherwise.
  - Go to FETCH.
- rd=x0: RF_wen still asserts; the register file ignores x0.
- TRAP: all strobes are 0, halt=1, fault is held. Only reset exits TRAP.
- Latency with zero-wait ack (FETCH through next FETCH): ALU/LUI/AUIPC/JAL/JALR 4 cycles, load 5, store 4, branch 3, FENCE 2.
- Wait counter clears on every state entry, so waits are independent.
- Simultaneous im_ack and count==TIMEOUT: ack wins. The same rule applies to dm_ack.
- RF_wen, PC_wen and IR_wen are single-cycle pulses per instruction; never assert them in the same cycle as a req without its ack.

Optional Feature:
MCU_PERF_COUNTERS_EN
- Defined: adds outputs cycle_cnt[63:0] (increments every non-reset cycle while halt=0) and instret_cnt[63:0] (increments on each transition into FETCH from DECODE/EXEC/MEM/WB). Both counters reset to 0 and freeze in TRAP.
- Undefined: neither port nor counter logic exists.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), im_ack and dm_ack tied 1 -> FETCH,DECODE,EXEC,WB; RF_wen=1 for exactly one cycle in WB with RF_wsel=3, RF_wdata_sel=ALU, ALU_Operation=ALU_ADD; PC_wen with PC_sel=0.
- LW x5,8(x1) with dm_ack delayed 3 cycles -> dm_req=1 and DM_wen=0 for 4 cycles; WB selects DM; total 8 cycles.
- BEQ with branch_taken=1, then BEQ with branch_taken=0 -> 3-cycle sequence each; PC_sel=1 then 0; branch_condition=000; RF_wen never asserts.
- JALR x1,0(x2) -> EXEC ALU_ADD with reg operand; WB RF_wdata_sel=PC+4, PC_sel=1.
- im_ack held 0 with TIMEOUT=4 -> TRAP after 5 cycles in FETCH; halt=1, fault=10; stays until rst_n=0 for one edge, then FETCH with all outputs clean.
- Opcode 0x7F, and separately ECALL -> TRAP from DECODE with fault=01; no RF_wen, PC_wen or dm_req; reset asserted mid-MEM drops dm_req on the next edge.
